vend_ctrl: RTL and testbench
============================

# vend_ctrl

Coin-intake and dispense controller for the vending machine. It accepts half-yuan and one-yuan coin pulses and accumulates credit in half-yuan units. Once the price is reached it issues a request/acknowledge handshake to the cola dispenser, then returns any change as a pulse train. It sits between the debounced coin-slot inputs and the dispenser, sequencing the dispense resource.

## Interface
- PRICE, 5, price in half-yuan units (5 = 2.5 yuan); legal range 1..(2^CREDIT_W-3)
- CREDIT_W, 4, credit register width; must hold PRICE+2
- TIMEOUT_CYC, 50_000_000, idle cycles after the last accepted coin before a refund (1 s at 50 MHz)
- sys_clk  in  1  clock, rising edge
- sys_rst_n  in  1  reset, asynchronous, active-low
- pi_money_half  in  1  one-cycle pulse, 0.5 yuan inserted
- pi_money_one  in  1  one-cycle pulse, 1 yuan inserted
- pi_cola_ack  in  1  dispenser accepted the request
- po_cola_req  out  1  dispense request, held until acknowledged
- po_change_pulse  out  1  one pulse per half-yuan returned
- po_coin_reject  out  1  one-cycle pulse: a coin arrived while busy and was not credited
- po_busy  out  1  high in VEND, CHANGE and REFUND
- po_credit  out  CREDIT_W  current credit, in half-yuan units

## Operation
- All outputs are registered. Reset value of every output is 0. Reset returns the state to IDLE and clears credit. Reset mid-operation discards credit; no change is emitted.
- States (one-hot): IDLE, ACCUM, VEND, CHANGE, REFUND.
- IDLE/ACCUM, coin value per cycle: half = 1, one = 2, both in the same cycle = 3.
  - next_credit = credit + value.
  - If next_credit >= PRICE, go to VEND. Else if value > 0, go to ACCUM.
- ACCUM with no coin: stays in ACCUM; the timeout counter increments.
- VEND:
  - po_cola_req is high.
  - On an edge with pi_cola_ack high: po_cola_req goes low and credit becomes credit - PRICE.
  - Then go to CHANGE if the remainder is > 0, else go to IDLE.
  - pi_cola_ack while req is low is ignored.
- CHANGE/REFUND:
  - po_change_pulse toggles: high 1 cycle, low 1 cycle.
  - Each high cycle decrements credit by 1.
  - The edge that decrements credit to 0 returns the state to IDLE, with the pulse ending low.
- A coin in VEND, CHANGE or REFUND is not credited. po_coin_reject pulses on the next cycle.
- Max credit is PRICE+2; there is no overflow by construction.

## Timing
- Coin at cycle t: po_credit updated at t+1. If the price is reached, po_cola_req is high at t+1.
- Ack sampled at cycle t: po_cola_req is low at t+1. The first change pulse is at t+2.
- Change of N half-yuan: pulses at cycles t+2, t+4, …, t+2N. Back in IDLE at t+2N+1.
- Timeout:
  - The counter clears on every accepted coin.
  - REFUND is entered on the edge where the counter reaches TIMEOUT_CYC-1.
  - The first refund pulse is on the next cycle.

## Configuration
- VEND_CTRL_TIMEOUT_EN defined: the timeout counter and the REFUND state are present; behaviour is as above.
- VEND_CTRL_TIMEOUT_EN not defined:
  - No counter, and REFUND is unreachable.
  - Credit in ACCUM is held indefinitely.
  - TIMEOUT_CYC is ignored.

## Structure
- Shared package vend_pkg holds:
  - state encoding constants;
  - coin values (COIN_HALF = 1, COIN_ONE = 2).
- Sub-module vend_change_gen:
  - loads a count and emits the alternating pulse train;
  - reports done;
  - is used by both CHANGE and REFUND.

## Test plan
- PRICE=5; insert one, one, half in separate cycles -> credit 2, 4, 5. po_cola_req is high the cycle after the half coin. Ack -> no change pulses, IDLE.
- Credit 4, then half and one in the same cycle -> credit 7, VEND. Ack -> exactly 2 change pulses, 2 cycles apart, then credit 0.
- Hold pi_cola_ack low for 20 cycles in VEND -> po_cola_req stays high and credit stays at 5. Insert a half coin -> po_coin_reject pulses once and credit is unchanged.
- TIMEOUT_CYC=16, macro defined: insert one coin then idle -> after 16 cycles, 2 refund pulses, then IDLE. With the macro undefined -> credit 2 is held for 100 cycles with no pulses.
- Assert sys_rst_n low during CHANGE after the first pulse -> all outputs are 0 immediately and credit is 0. After release, a coin is credited normally.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: one-hot state encoding and coin values.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vend_pkg;

  // One-hot controller states
  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_ACCUM  = 5'b00010,
    S_VEND   = 5'b00100,
    S_CHANGE = 5'b01000,
    S_REFUND = 5'b10000
  } vend_state_e;

  // Coin values in half-yuan units
  localparam logic [1:0] COIN_HALF = 2'd1;
  localparam logic [1:0] COIN_ONE  = 2'd2;

  // Value of the coins seen in one cycle; both slots at once add up to 3
  function automatic logic [1:0] coin_value(input logic half, input logic one);
    logic [1:0] v;
    v = (half ? COIN_HALF : 2'd0) | (one ? COIN_ONE : 2'd0);
    return v;
  endfunction

endpackage

// File: rtl/vend_change_gen.sv
// Change/refund pulse generator: loads a half-yuan count and emits high/low alternating pulses.
// Latency: first pulse two cycles after load, one pulse every two cycles, done on the last high cycle.
// Backpressure: none; the train runs to completion once loaded.
module vend_change_gen
  import vend_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          load_i,
  input  logic [CW-1:0] count_i,
  output logic          pulse_o,
  output logic          dec_o,
  output logic          done_o
);

  logic [CW-1:0] cnt_q;
  logic          active_q;
  logic          pulse_q;

  // Pulse train: a low cycle after load, then high/low pairs until the count is exhausted
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else if (load_i) begin
      cnt_q    <= count_i;
      active_q <= (count_i != '0);
      pulse_q  <= 1'b0;
    end else if (active_q) begin
      if (!pulse_q) begin
        pulse_q <= 1'b1;
      end else begin
        pulse_q <= 1'b0;
        cnt_q   <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          active_q <= 1'b0;
        end
      end
    end
  end

  // The edge that ends a high cycle consumes one half-yuan; the last one finishes the train
  assign pulse_o = pulse_q;
  assign dec_o   = active_q & pulse_q;
  assign done_o  = dec_o & (cnt_q == CW'(1));

endmodule

// File: rtl/vend_ctrl.sv
// Coin-intake and dispense controller: accumulates credit, handshakes with the dispenser, returns change.
// Latency: credit and cola request update one cycle after a coin; change pulses start two cycles after ack.
// Backpressure: coins arriving while busy are not credited and are flagged on po_coin_reject.
// Optional idle-credit refund timeout is built when VEND_CTRL_TIMEOUT_EN is defined.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE       = 5,
  parameter int CREDIT_W    = 4,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                pi_money_half,
  input  logic                pi_money_one,
  input  logic                pi_cola_ack,
  output logic                po_cola_req,
  output logic                po_change_pulse,
  output logic                po_coin_reject,
  output logic                po_busy,
  output logic [CREDIT_W-1:0] po_credit
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  vend_state_e         state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic                req_q;
  logic                reject_q;
  logic                busy_q;

  logic [1:0]          coin_val;
  logic                coin_any;
  logic [CREDIT_W-1:0] credit_sum;
  logic [CREDIT_W-1:0] remainder;
  logic                vend_ack;
  logic                tmo_fire;

  logic                chg_load;
  logic [CREDIT_W-1:0] chg_count;
  logic                chg_pulse;
  logic                chg_dec;
  logic                chg_done;

  assign coin_val   = coin_value(pi_money_half, pi_money_one);
  assign coin_any   = pi_money_half | pi_money_one;
  // Credit never exceeds PRICE+2, so the sum cannot wrap
  assign credit_sum = credit_q + CREDIT_W'(coin_val);
  assign remainder  = credit_q - PRICE_C;
  assign vend_ack   = (state_q == S_VEND) && req_q && pi_cola_ack;

`ifdef VEND_CTRL_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 2);

  logic [TMO_W-1:0] tmo_q;

  // Refund fires on the edge where the idle counter would reach TIMEOUT_CYC-1
  assign tmo_fire = (state_q == S_ACCUM) && !coin_any && (tmo_q == TMO_LAST);

  // Idle counter: runs only in ACCUM with no coin, cleared by every accepted coin
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tmo_q <= '0;
    end else if ((state_q == S_ACCUM) && !coin_any) begin
      tmo_q <= tmo_q + TMO_W'(1);
    end else begin
      tmo_q <= '0;
    end
  end
`else
  // No refund path: credit in ACCUM is held until more coins arrive
  assign tmo_fire = 1'b0 & (TIMEOUT_CYC == 0);
`endif

  // Change after a vend uses the remainder; a refund returns the whole credit
  assign chg_load  = (vend_ack && (remainder != '0)) || tmo_fire;
  assign chg_count = (state_q == S_VEND) ? remainder : credit_q;

  vend_change_gen #(
    .CW (CREDIT_W)
  ) u_change_gen (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load_i    (chg_load),
    .count_i   (chg_count),
    .pulse_o   (chg_pulse),
    .dec_o     (chg_dec),
    .done_o    (chg_done)
  );

  // Main FSM with registered request, reject, busy and credit outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      req_q    <= 1'b0;
      reject_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      reject_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_ACCUM: begin
          credit_q <= credit_sum;
          if (credit_sum >= PRICE_C) begin
            state_q <= S_VEND;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
          end else if (coin_any) begin
            state_q <= S_ACCUM;
          end else if (tmo_fire) begin
            state_q <= S_REFUND;
            busy_q  <= 1'b1;
          end
        end
        S_VEND: begin
          reject_q <= coin_any;
          if (vend_ack) begin
            req_q    <= 1'b0;
            credit_q <= remainder;
            if (remainder != '0) begin
              state_q <= S_CHANGE;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        S_CHANGE, S_REFUND: begin
          reject_q <= coin_any;
          if (chg_dec) begin
            credit_q <= credit_q - CREDIT_W'(1);
          end
          if (chg_done) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          credit_q <= '0;
          req_q    <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign po_cola_req     = req_q;
  assign po_change_pulse = chg_pulse;
  assign po_coin_reject  = reject_q;
  assign po_busy         = busy_q;
  assign po_credit       = credit_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: vector table plus hand-written multi-cycle sequences, checked through a scoreboard queue.
// Inputs change one time unit after the rising edge; outputs are sampled at that same point.
// Timeout behaviour checked follows whether VEND_CTRL_TIMEOUT_EN is defined.
module tb_vend_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       pi_money_half;
  logic       pi_money_one;
  logic       pi_cola_ack;
  logic       po_cola_req;
  logic       po_change_pulse;
  logic       po_coin_reject;
  logic       po_busy;
  logic [3:0] po_credit;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [3:0] credit;
    logic       req;
    logic       pulse;
    logic       rej;
    logic       busy;
  } exp_t;

  typedef struct {
    logic half;
    logic one;
    logic ack;
    exp_t exp;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[17];

  vend_ctrl #(
    .PRICE       (5),
    .CREDIT_W    (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .pi_money_half   (pi_money_half),
    .pi_money_one    (pi_money_one),
    .pi_cola_ack     (pi_cola_ack),
    .po_cola_req     (po_cola_req),
    .po_change_pulse (po_change_pulse),
    .po_coin_reject  (po_coin_reject),
    .po_busy         (po_busy),
    .po_credit       (po_credit)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic exp_t ex(input int c, input bit r, input bit p, input bit j, input bit b);
    exp_t e;
    e.credit = 4'(c);
    e.req    = r;
    e.pulse  = p;
    e.rej    = j;
    e.busy   = b;
    return e;
  endfunction

  function automatic vec_t mk(input bit h, input bit o, input bit a, input exp_t e);
    vec_t v;
    v.half = h;
    v.one  = o;
    v.ack  = a;
    v.exp  = e;
    return v;
  endfunction

  function automatic exp_t sample();
    exp_t a;
    a.credit = po_credit;
    a.req    = po_cola_req;
    a.pulse  = po_change_pulse;
    a.rej    = po_coin_reject;
    a.busy   = po_busy;
    return a;
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got credit=%0d req=%b pulse=%b rej=%b busy=%b, want credit=%0d req=%b pulse=%b rej=%b busy=%b",
               name, act.credit, act.req, act.pulse, act.rej, act.busy,
               exp.credit, exp.req, exp.pulse, exp.rej, exp.busy);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, compare after the edge
  task automatic apply(input logic h, input logic o, input logic a, input exp_t e, input string name);
    exp_t want;
    pi_money_half = h;
    pi_money_one  = o;
    pi_cola_ack   = a;
    sb_q.push_back(e);
    @(posedge sys_clk);
    #1;
    pi_money_half = 1'b0;
    pi_money_one  = 1'b0;
    pi_cola_ack   = 1'b0;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      want = sb_q.pop_front();
      check(name, sample(), want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n     = 1'b0;
    pi_money_half = 1'b0;
    pi_money_one  = 1'b0;
    pi_cola_ack   = 1'b0;

    // Exact price via one, one, half; then 7 with both coins and two change pulses
    vecs[0]  = mk(0, 0, 0, ex(0, 0, 0, 0, 0));
    vecs[1]  = mk(0, 1, 0, ex(2, 0, 0, 0, 0));
    vecs[2]  = mk(0, 1, 0, ex(4, 0, 0, 0, 0));
    vecs[3]  = mk(1, 0, 0, ex(5, 1, 0, 0, 1));
    vecs[4]  = mk(0, 0, 1, ex(0, 0, 0, 0, 0));
    vecs[5]  = mk(0, 0, 1, ex(0, 0, 0, 0, 0));
    vecs[6]  = mk(0, 0, 0, ex(0, 0, 0, 0, 0));
    vecs[7]  = mk(0, 1, 0, ex(2, 0, 0, 0, 0));
    vecs[8]  = mk(0, 1, 0, ex(4, 0, 0, 0, 0));
    vecs[9]  = mk(1, 1, 0, ex(7, 1, 0, 0, 1));
    vecs[10] = mk(0, 0, 0, ex(7, 1, 0, 0, 1));
    vecs[11] = mk(0, 0, 1, ex(2, 0, 0, 0, 1));
    vecs[12] = mk(0, 0, 0, ex(2, 0, 1, 0, 1));
    vecs[13] = mk(1, 0, 0, ex(1, 0, 0, 1, 1));
    vecs[14] = mk(0, 0, 1, ex(1, 0, 1, 0, 1));
    vecs[15] = mk(0, 0, 0, ex(0, 0, 0, 0, 0));
    vecs[16] = mk(0, 0, 0, ex(0, 0, 0, 0, 0));

    #12;
    check("reset_state", sample(), ex(0, 0, 0, 0, 0));
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      apply(vecs[i].half, vecs[i].one, vecs[i].ack, vecs[i].exp, $sformatf("vec[%0d]", i));
    end

    // Dispenser stalls: request and credit hold, a coin in VEND is rejected once
    apply(0, 1, 0, ex(2, 0, 0, 0, 0), "stall_coin1");
    apply(0, 1, 0, ex(4, 0, 0, 0, 0), "stall_coin2");
    apply(1, 0, 0, ex(5, 1, 0, 0, 1), "stall_coin3");
    for (int i = 0; i < 20; i++) begin
      apply(0, 0, 0, ex(5, 1, 0, 0, 1), $sformatf("stall_hold[%0d]", i));
    end
    apply(1, 0, 0, ex(5, 1, 0, 1, 1), "stall_reject");
    apply(0, 0, 0, ex(5, 1, 0, 0, 1), "stall_reject_end");
    apply(0, 0, 1, ex(0, 0, 0, 0, 0), "stall_ack");

`ifdef VEND_CTRL_TIMEOUT_EN
    // Idle credit of 2 is refunded: REFUND after 15 idle cycles, pulses at 16 and 18
    apply(0, 1, 0, ex(2, 0, 0, 0, 0), "tmo_coin");
    for (int k = 1; k <= 14; k++) begin
      apply(0, 0, 0, ex(2, 0, 0, 0, 0), $sformatf("tmo_wait[%0d]", k));
    end
    apply(0, 0, 0, ex(2, 0, 0, 0, 1), "tmo_refund_enter");
    apply(0, 0, 0, ex(2, 0, 1, 0, 1), "tmo_pulse1");
    apply(0, 0, 0, ex(1, 0, 0, 0, 1), "tmo_gap");
    apply(0, 0, 0, ex(1, 0, 1, 0, 1), "tmo_pulse2");
    apply(0, 0, 0, ex(0, 0, 0, 0, 0), "tmo_idle");
    apply(0, 0, 0, ex(0, 0, 0, 0, 0), "tmo_idle2");
`else
    // Without the timeout, credit sits in ACCUM with no pulses
    apply(0, 1, 0, ex(2, 0, 0, 0, 0), "hold_coin");
    for (int k = 0; k < 100; k++) begin
      apply(0, 0, 0, ex(2, 0, 0, 0, 0), $sformatf("hold_wait[%0d]", k));
    end
    apply(1, 1, 0, ex(5, 1, 0, 0, 1), "hold_vend");
    apply(0, 0, 1, ex(0, 0, 0, 0, 0), "hold_ack");
`endif

    // Reset during CHANGE after the first pulse discards the remaining change
    apply(0, 1, 0, ex(2, 0, 0, 0, 0), "rst_coin1");
    apply(0, 1, 0, ex(4, 0, 0, 0, 0), "rst_coin2");
    apply(1, 1, 0, ex(7, 1, 0, 0, 1), "rst_coin3");
    apply(0, 0, 1, ex(2, 0, 0, 0, 1), "rst_ack");
    apply(0, 0, 0, ex(2, 0, 1, 0, 1), "rst_pulse1");
    apply(0, 0, 0, ex(1, 0, 0, 0, 1), "rst_gap");
    sys_rst_n = 1'b0;
    #1;
    check("rst_async", sample(), ex(0, 0, 0, 0, 0));
    @(posedge sys_clk);
    #1;
    check("rst_held", sample(), ex(0, 0, 0, 0, 0));
    sys_rst_n = 1'b1;
    apply(0, 1, 0, ex(2, 0, 0, 0, 0), "post_rst_coin");
    apply(0, 0, 0, ex(2, 0, 0, 0, 0), "post_rst_hold");

    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, want 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
